// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default NOP word, instruction field positions
// and the width of the ID/EX control word.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int INSTR_W = 32;
  localparam int REG_W   = 5;
  localparam int OP_W    = 6;
  localparam int CTRL_W  = 8;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;

  localparam logic [INSTR_W-1:0] PC_STEP = 32'd4;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard check: a load in EX whose destination
// matches either source of a valid instruction in ID. Register 0 never hazards.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic             mem_read,
  input  logic             valid,
  input  logic [REG_W-1:0] rt_ex,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  output logic             hazard
);

  logic dst_nonzero;
  logic src_match;

  always_comb begin
    dst_nonzero = (rt_ex != '0);
    src_match   = (rt_ex == rs_id) || (rt_ex == rt_id);
    hazard      = mem_read && valid && dst_nonzero && src_match;
  end

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage: PC register, IF/ID pipeline register, load-use stall,
// redirect flush and saturating stall/flush event counters.
module if_id_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR,
  parameter int          CNT_W     = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [31:0]       Instr_IF,
  input  logic              Hold_IF,
  input  logic              Redirect,
  input  logic [31:0]       Redirect_PC,
  input  logic              MemRead_EX,
  input  logic [4:0]        Rt_EX,
  output logic [31:0]       PC_IF,
  output logic [31:0]       PC4_ID,
  output logic [31:0]       Instr_ID,
  output logic [5:0]        OpCode_ID,
  output logic [4:0]        Rs_ID,
  output logic [4:0]        Rt_ID,
  output logic [4:0]        Rd_ID,
  output logic              Valid_ID,
  output logic              Stall,
  output logic              Bubble_ID,
  output logic [CNT_W-1:0]  Stall_Count,
  output logic [CNT_W-1:0]  Flush_Count
);

  logic [31:0]      pc_p0;
  logic [31:0]      instr_p1;
  logic [31:0]      pc4_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic [31:0]      pc_next;
  logic             lu;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    pc_next   = pc_p0 + PC_STEP;
    OpCode_ID = instr_p1[OP_MSB:OP_LSB];
    Rs_ID     = instr_p1[RS_MSB:RS_LSB];
    Rt_ID     = instr_p1[RT_MSB:RT_LSB];
    Rd_ID     = instr_p1[RD_MSB:RD_LSB];
  end

  hazard_detect u_hazard (
    .mem_read (MemRead_EX),
    .valid    (vld_p1),
    .rt_ex    (Rt_EX),
    .rs_id    (Rs_ID),
    .rt_id    (Rt_ID),
    .hazard   (lu)
  );

  // A redirect squashes the ID instruction, so it also cancels any stall on it.
  always_comb begin
    Stall     = lu && !Redirect;
    Bubble_ID = Stall || Redirect || !vld_p1;
  end

  // IF -> ID boundary: PC register and IF/ID register, priority redirect > stall > hold > advance
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pc_p0     <= RESET_PC;
      instr_p1  <= NOP_INSTR;
      pc4_p1    <= '0;
      vld_p1    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (Redirect) begin
      pc_p0     <= Redirect_PC;
      instr_p1  <= NOP_INSTR;
      vld_p1    <= 1'b0;
      flush_cnt <= sat_inc(flush_cnt);
    end else if (lu) begin
      stall_cnt <= sat_inc(stall_cnt);
    end else if (Hold_IF) begin
      instr_p1  <= NOP_INSTR;
      vld_p1    <= 1'b0;
    end else begin
      pc_p0     <= pc_next;
      instr_p1  <= Instr_IF;
      pc4_p1    <= pc_next;
      vld_p1    <= 1'b1;
    end
  end

  assign PC_IF       = pc_p0;
  assign PC4_ID      = pc4_p1;
  assign Instr_ID    = instr_p1;
  assign Valid_ID    = vld_p1;
  assign Stall_Count = stall_cnt;
  assign Flush_Count = flush_cnt;

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: a behavioural model predicts each cycle's
// registered state, which is queued at drive time and compared after the edge.
module tb_if_id_stage;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] Instr_IF;
  logic        Hold_IF;
  logic        Redirect;
  logic [31:0] Redirect_PC;
  logic        MemRead_EX;
  logic [4:0]  Rt_EX;

  logic [31:0] PC_IF, PC4_ID, Instr_ID;
  logic [5:0]  OpCode_ID;
  logic [4:0]  Rs_ID, Rt_ID, Rd_ID;
  logic        Valid_ID, Stall, Bubble_ID;
  logic [15:0] Stall_Count, Flush_Count;

  logic [31:0] s_PC_IF, s_PC4_ID, s_Instr_ID;
  logic [5:0]  s_OpCode_ID;
  logic [4:0]  s_Rs_ID, s_Rt_ID, s_Rd_ID;
  logic        s_Valid_ID, s_Stall, s_Bubble_ID;
  logic [2:0]  s_Stall_Count, s_Flush_Count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        vld;
    logic [15:0] sc;
    logic [15:0] fc;
    logic [2:0]  sc_s;
    logic [2:0]  fc_s;
  } exp_t;

  exp_t sb[$];

  // model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_vld;
  logic [15:0] m_sc, m_fc;
  logic [2:0]  m_sc_s, m_fc_s;

  if_id_stage u_dut (
    .Clk(Clk), .Rst(Rst), .Instr_IF(Instr_IF), .Hold_IF(Hold_IF),
    .Redirect(Redirect), .Redirect_PC(Redirect_PC), .MemRead_EX(MemRead_EX),
    .Rt_EX(Rt_EX), .PC_IF(PC_IF), .PC4_ID(PC4_ID), .Instr_ID(Instr_ID),
    .OpCode_ID(OpCode_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Rd_ID(Rd_ID),
    .Valid_ID(Valid_ID), .Stall(Stall), .Bubble_ID(Bubble_ID),
    .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
  );

  // Narrow-counter instance so saturation is reachable in a few cycles.
  if_id_stage #(.CNT_W(3)) u_sat (
    .Clk(Clk), .Rst(Rst), .Instr_IF(Instr_IF), .Hold_IF(Hold_IF),
    .Redirect(Redirect), .Redirect_PC(Redirect_PC), .MemRead_EX(MemRead_EX),
    .Rt_EX(Rt_EX), .PC_IF(s_PC_IF), .PC4_ID(s_PC4_ID), .Instr_ID(s_Instr_ID),
    .OpCode_ID(s_OpCode_ID), .Rs_ID(s_Rs_ID), .Rt_ID(s_Rt_ID), .Rd_ID(s_Rd_ID),
    .Valid_ID(s_Valid_ID), .Stall(s_Stall), .Bubble_ID(s_Bubble_ID),
    .Stall_Count(s_Stall_Count), .Flush_Count(s_Flush_Count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_vld = 1'b0;
    m_sc = '0; m_fc = '0; m_sc_s = '0; m_fc_s = '0;
  endtask

  function automatic logic model_lu();
    model_lu = MemRead_EX && m_vld && (Rt_EX != 5'd0) &&
               ((Rt_EX == m_instr[25:21]) || (Rt_EX == m_instr[20:16]));
  endfunction

  // One clock: check combinational outputs, predict, push, clock, pop, compare.
  task automatic step(input string tag);
    exp_t e;
    logic lu, exp_stall, exp_bub;
    #1;
    lu        = model_lu();
    exp_stall = lu && !Redirect;
    exp_bub   = exp_stall || Redirect || !m_vld;
    check({tag, ".stall"},  {31'b0, Stall},     {31'b0, exp_stall});
    check({tag, ".bubble"}, {31'b0, Bubble_ID}, {31'b0, exp_bub});
    check({tag, ".stall_s"}, {31'b0, s_Stall},  {31'b0, exp_stall});
    if (Redirect) begin
      m_pc = Redirect_PC; m_instr = 32'h0; m_vld = 1'b0;
      if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
      if (m_fc_s != 3'h7) m_fc_s = m_fc_s + 3'd1;
    end else if (lu) begin
      if (m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
      if (m_sc_s != 3'h7) m_sc_s = m_sc_s + 3'd1;
    end else if (Hold_IF) begin
      m_instr = 32'h0; m_vld = 1'b0;
    end else begin
      m_instr = Instr_IF; m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_vld = 1'b1;
    end
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.vld = m_vld;
    e.sc = m_sc; e.fc = m_fc; e.sc_s = m_sc_s; e.fc_s = m_fc_s;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    check({tag, ".pc"},    PC_IF,    e.pc);
    check({tag, ".instr"}, Instr_ID, e.instr);
    check({tag, ".pc4"},   PC4_ID,   e.pc4);
    check({tag, ".valid"}, {31'b0, Valid_ID}, {31'b0, e.vld});
    check({tag, ".op"},    {26'b0, OpCode_ID}, {26'b0, e.instr[31:26]});
    check({tag, ".rs"},    {27'b0, Rs_ID}, {27'b0, e.instr[25:21]});
    check({tag, ".rt"},    {27'b0, Rt_ID}, {27'b0, e.instr[20:16]});
    check({tag, ".rd"},    {27'b0, Rd_ID}, {27'b0, e.instr[15:11]});
    check({tag, ".scnt"},  {16'b0, Stall_Count}, {16'b0, e.sc});
    check({tag, ".fcnt"},  {16'b0, Flush_Count}, {16'b0, e.fc});
    check({tag, ".scnt_s"}, {29'b0, s_Stall_Count}, {29'b0, e.sc_s});
    check({tag, ".fcnt_s"}, {29'b0, s_Flush_Count}, {29'b0, e.fc_s});
  endtask

  task automatic idle_inputs();
    Hold_IF = 1'b0; Redirect = 1'b0; Redirect_PC = 32'h0;
    MemRead_EX = 1'b0; Rt_EX = 5'd0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".pc"},     PC_IF,    32'h0);
    check({tag, ".instr"},  Instr_ID, 32'h0);
    check({tag, ".pc4"},    PC4_ID,   32'h0);
    check({tag, ".valid"},  {31'b0, Valid_ID},  32'h0);
    check({tag, ".stall"},  {31'b0, Stall},     32'h0);
    check({tag, ".bubble"}, {31'b0, Bubble_ID}, 32'h1);
    check({tag, ".scnt"},   {16'b0, Stall_Count}, 32'h0);
    check({tag, ".fcnt"},   {16'b0, Flush_Count}, 32'h0);
  endtask

  initial begin
    Rst = 1'b1;
    Instr_IF = 32'h0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check_reset_state("reset");
    Rst = 1'b0;

    // a few normal fetches, then an asynchronous reset pulse mid-cycle
    for (int i = 0; i < 3; i++) begin
      Instr_IF = 32'h2000_0000 | i;
      step("warm");
    end
    #2 Rst = 1'b1;
    #1;
    check_reset_state("async_rst");
    model_reset();
    #1 Rst = 1'b0;

    Instr_IF = 32'h8C22_0004;
    step("first_fetch");

    // load-use on Rs=2
    Instr_IF = 32'h0043_1020;
    step("fetch_add");
    Instr_IF = 32'hDEAD_0001;
    MemRead_EX = 1'b1; Rt_EX = 5'd2;
    step("lu_stall");
    MemRead_EX = 1'b0;
    step("lu_resume");

    // no hazard on $zero
    Instr_IF = 32'h0000_1020;
    step("fetch_zero");
    MemRead_EX = 1'b1; Rt_EX = 5'd0;
    step("zero_nohaz");
    MemRead_EX = 1'b0;

    // redirect while a load-use hazard is present
    Instr_IF = 32'h0045_1020;
    step("fetch_rs2");
    MemRead_EX = 1'b1; Rt_EX = 5'd2; Redirect = 1'b1; Redirect_PC = 32'h40;
    step("redirect_lu");
    idle_inputs();

    // instruction memory hold for three cycles
    Instr_IF = 32'h1111_2222;
    step("pre_hold");
    Hold_IF = 1'b1;
    for (int i = 0; i < 3; i++) step("hold");
    Hold_IF = 1'b0;
    Instr_IF = 32'h3333_4444;
    step("hold_release");
    step("post_hold");

    // back-to-back load-use cycles saturate the narrow counter
    Instr_IF = 32'h00A5_3020;
    step("fetch_rs5");
    MemRead_EX = 1'b1; Rt_EX = 5'd5;
    for (int i = 0; i < 10; i++) step("lu_sat");
    MemRead_EX = 1'b0;

    // PC wrap at the top of the address space
    Redirect = 1'b1; Redirect_PC = 32'hFFFF_FFFC;
    step("redir_top");
    Redirect = 1'b0;
    Instr_IF = 32'h5555_6666;
    step("pc_wrap");
    step("after_wrap");

    // repeated redirects saturate the narrow flush counter
    Redirect = 1'b1;
    for (int i = 0; i < 9; i++) begin
      Redirect_PC = 32'h100 + 32'(i * 16);
      step("fc_sat");
    end
    Redirect = 1'b0;

    // randomized mix
    for (int i = 0; i < 300; i++) begin
      Instr_IF    = $urandom();
      Instr_IF[25:21] = 5'($urandom_range(0, 3));
      Instr_IF[20:16] = 5'($urandom_range(0, 3));
      Hold_IF     = ($urandom_range(0, 3) == 0);
      Redirect    = ($urandom_range(0, 9) == 0);
      Redirect_PC = {$urandom(), 2'b00} >> 0;
      MemRead_EX  = ($urandom_range(0, 1) == 0);
      Rt_EX       = 5'($urandom_range(0, 3));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case the stimulus process ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
